keypad_scanner: RTL and testbench

- Transmitter end of the keypad digit interface: scans a 4x3 key matrix, debounces it, and emits one `digit`/`loadn` strobe per accepted keystroke.
- Feeds the timer's shift-load path and the keypad `enable` gating.
- Also produces active-low start/clear key pulses that can drive the magnetron control inputs.
- Replaces the ten discrete key wires with a scanned, debounced source.

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/keypad_col_scan.sv | 75 +++++++
 rtl/keypad_scanner.sv | 156 +++++++++++++++
 tb/tb_keypad_scanner.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types, constants and key-code lookup for the scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } scan_result_t;

  // Rows 0..2 hold digits 1..9 in reading order; row 3 is '*', '0', '#'.
  function automatic logic [3:0] key_code(input int row, input int col);
    logic [3:0] code;
    if (row == NUM_ROWS - 1) begin
      if (col == 0)      code = KEY_STAR;
      else if (col == 1) code = 4'd0;
      else               code = KEY_HASH;
    end else begin
      code = 4'(row * NUM_COLS + col + 1);
    end
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_col_scan.sv
`default_nettype none
// ============================================================================
// Module      : keypad_col_scan
// Description : Column driver, row synchroniser and 12-bit key vector builder.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic                clock,
  input  logic                clearn,
  input  logic [NUM_ROWS-1:0] rows_n,
  output logic [NUM_COLS-1:0] cols_n,
  output logic                scan_end,
  output logic [NUM_KEYS-1:0] key_vec
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]    r_div;
  logic [1:0]          r_col;
  logic [NUM_COLS-1:0] r_cols_n;
  logic [NUM_ROWS-1:0] r_sync1;
  logic [NUM_ROWS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_vec;
  logic [NUM_KEYS-1:0] w_vec;
  logic                w_sample;

  assign w_sample = (r_div == c_div_last);

  // The vector seen at scan end already includes the column being sampled.
  always_comb begin
    w_vec = r_vec;
    if (w_sample) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          if (r_col == 2'(c)) begin
            w_vec[r*NUM_COLS + c] = ~r_sync2[r];
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_div    <= '0;
      r_col    <= 2'd0;
      r_cols_n <= 3'b110;
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_vec    <= '0;
    end else begin
      r_sync1 <= rows_n;
      r_sync2 <= r_sync1;
      r_vec   <= w_vec;
      if (w_sample) begin
        r_div    <= '0;
        r_col    <= (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
        r_cols_n <= {r_cols_n[NUM_COLS-2:0], r_cols_n[NUM_COLS-1]};
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  assign cols_n   = r_cols_n;
  assign scan_end = w_sample && (r_col == 2'd2);
  assign key_vec  = w_vec;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : Debounced 4x3 keypad scanner emitting digit/start/clear strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic [3:0] rows_n,
  input  logic       enable,
  output logic [2:0] cols_n,
  output logic [3:0] digit,
  output logic       loadn,
  output logic       start_key_n,
  output logic       clear_key_n
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] c_cnt_done = CNT_W'(DEBOUNCE_SCANS);

  logic                w_scan_end;
  logic [NUM_KEYS-1:0] w_key_vec;
  logic [3:0]          w_hits;
  logic [3:0]          w_code;
  scan_result_t        w_result;

  state_t              r_state;
  state_t              w_state_nx;
  logic [3:0]          r_code;
  logic [3:0]          w_code_nx;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic [CNT_W-1:0]    w_cnt_inc;

  logic                w_emit_nx;
  logic                w_load_nx;
  logic [3:0]          r_digit;
  logic                r_loadn;
  logic                r_start_n;
  logic                r_clear_n;

  keypad_col_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_col_scan (
    .clock    (clock),
    .clearn   (clearn),
    .rows_n   (rows_n),
    .cols_n   (cols_n),
    .scan_end (w_scan_end),
    .key_vec  (w_key_vec)
  );

  // Classify the completed scan; w_code is meaningful only for SINGLE.
  always_comb begin
    w_hits = '0;
    w_code = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (w_key_vec[r*NUM_COLS + c]) begin
          w_hits = w_hits + 4'd1;
          w_code = key_code(r, c);
        end
      end
    end
    if (w_hits == 4'd0)      w_result = NONE;
    else if (w_hits == 4'd1) w_result = SINGLE;
    else                     w_result = MULTI;
  end

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nx = r_state;
    w_code_nx  = r_code;
    w_cnt_nx   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_scan_end && (w_result == SINGLE)) begin
          w_code_nx = w_code;
          w_cnt_nx  = CNT_W'(1);
          if (DEBOUNCE_SCANS == 1) w_state_nx = EMIT;
          else                     w_state_nx = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (w_scan_end) begin
          if ((w_result == SINGLE) && (w_code == r_code)) begin
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc == c_cnt_done) w_state_nx = EMIT;
          end else begin
            w_cnt_nx   = '0;
            w_state_nx = IDLE;
          end
        end
      end
      EMIT: begin
        w_cnt_nx   = '0;
        w_state_nx = RELEASE;
      end
      RELEASE: begin
        if (w_scan_end) begin
          if (w_result == NONE) begin
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc == c_cnt_done) begin
              w_cnt_nx   = '0;
              w_state_nx = IDLE;
            end
          end else begin
            w_cnt_nx = '0;
          end
        end
      end
      default: begin
        w_cnt_nx   = '0;
        w_state_nx = IDLE;
      end
    endcase
  end

  // Strobes are registered on entry to EMIT so they are low exactly during it.
  assign w_emit_nx = (w_state_nx == EMIT);
  assign w_load_nx = w_emit_nx && (w_code_nx <= 4'd9) && !enable;

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_state   <= IDLE;
      r_code    <= '0;
      r_cnt     <= '0;
      r_digit   <= '0;
      r_loadn   <= 1'b1;
      r_start_n <= 1'b1;
      r_clear_n <= 1'b1;
    end else begin
      r_state   <= w_state_nx;
      r_code    <= w_code_nx;
      r_cnt     <= w_cnt_nx;
      r_loadn   <= !w_load_nx;
      r_start_n <= !(w_emit_nx && (w_code_nx == KEY_STAR));
      r_clear_n <= !(w_emit_nx && (w_code_nx == KEY_HASH));
      if (w_load_nx) r_digit <= w_code_nx;
    end
  end

  assign digit       = r_digit;
  assign loadn       = r_loadn;
  assign start_key_n = r_start_n;
  assign clear_key_n = r_clear_n;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench with a key-matrix model and scan-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int SCAN_LEN = 3 * SCAN_DIV;

  logic        clock   = 1'b0;
  logic        clearn  = 1'b0;
  logic        enable  = 1'b0;
  logic [3:0]  rows_n;
  logic [2:0]  cols_n;
  logic [3:0]  digit;
  logic        loadn;
  logic        start_key_n;
  logic        clear_key_n;
  logic [11:0] pressed = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int seg_load, seg_start, seg_clear;

  // Reference model state: key index r*3+c maps to code_of[]
  int code_of[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
  int m_digit;
  bit m_armed;
  int m_code, m_run, m_rel;

  typedef struct {
    logic [11:0] keys;
    logic        en;
    int          scans;
    int          n_load;
    int          n_start;
    int          n_clear;
    int          digit_end;
  } vec_t;
  vec_t tbl[20];

  always #5 clock = ~clock;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clock       (clock),
    .clearn      (clearn),
    .rows_n      (rows_n),
    .enable      (enable),
    .cols_n      (cols_n),
    .digit       (digit),
    .loadn       (loadn),
    .start_key_n (start_key_n),
    .clear_key_n (clear_key_n)
  );

  always_comb begin
    rows_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3 + c] && !cols_n[c]) rows_n[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_digit = 0; m_armed = 1; m_code = 0; m_run = 0; m_rel = 0;
  endtask

  task automatic model_scan(input logic [11:0] keys, input logic en,
                            output bit f_load, output bit f_start, output bit f_clear);
    int nk, c;
    f_load = 0; f_start = 0; f_clear = 0;
    nk = $countones(keys);
    c = -1;
    for (int i = 0; i < 12; i++) if (keys[i]) c = code_of[i];
    if (m_armed) begin
      if (nk == 1 && (m_run == 0 || c == m_code)) begin
        if (m_run == 0) m_code = c;
        m_run++;
        if (m_run == DEB) begin
          m_armed = 0; m_run = 0; m_rel = 0;
          if (m_code == 10)      f_start = 1;
          else if (m_code == 11) f_clear = 1;
          else if (!en) begin
            f_load  = 1;
            m_digit = m_code;
          end
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (nk == 0) begin
        m_rel++;
        if (m_rel == DEB) begin m_armed = 1; m_rel = 0; end
      end else begin
        m_rel = 0;
      end
    end
  endtask

  task automatic check_cycle(input int p, input bit e_load, input bit e_start, input bit e_clear);
    logic [2:0] e_cols;
    e_cols = ~(3'b001 << (p / SCAN_DIV));
    check("cols_n", cols_n, e_cols);
    check("loadn", loadn, e_load);
    check("start_key_n", start_key_n, e_start);
    check("clear_key_n", clear_key_n, e_clear);
    check("digit", digit, m_digit);
    if (!loadn)       seg_load++;
    if (!start_key_n) seg_start++;
    if (!clear_key_n) seg_clear++;
  endtask

  // Entered and left at the negedge of the first cycle of a scan.
  task automatic run_scan(input logic [11:0] keys, input logic en);
    bit fl, fs, fc;
    pressed = keys;
    enable  = en;
    for (int p = 1; p <= SCAN_LEN; p++) begin
      @(posedge clock);
      @(negedge clock);
      if (p == SCAN_LEN) begin
        model_scan(keys, en, fl, fs, fc);
        check_cycle(0, !fl, !fs, !fc);
      end else begin
        check_cycle(p, 1'b1, 1'b1, 1'b1);
      end
    end
  endtask

  task automatic check_reset_values();
    check("rst_cols_n", cols_n, 3'b110);
    check("rst_digit", digit, 4'd0);
    check("rst_loadn", loadn, 1'b1);
    check("rst_start", start_key_n, 1'b1);
    check("rst_clear", clear_key_n, 1'b1);
  endtask

  task automatic check_segment(input int idx, input int n_load, input int n_start,
                               input int n_clear, input int dig);
    check($sformatf("seg%0d_loads", idx), seg_load, n_load);
    check($sformatf("seg%0d_starts", idx), seg_start, n_start);
    check($sformatf("seg%0d_clears", idx), seg_clear, n_clear);
    check($sformatf("seg%0d_digit", idx), digit, dig);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] rk;
    logic        ren;
    int          sel;

    tbl[0]  = '{12'h010, 1'b0, 10, 1, 0, 0, 5};  // hold '5'
    tbl[1]  = '{12'h000, 1'b0,  3, 0, 0, 0, 5};
    tbl[2]  = '{12'h080, 1'b0,  1, 0, 0, 0, 5};  // bouncing '8'
    tbl[3]  = '{12'h000, 1'b0,  2, 0, 0, 0, 5};
    tbl[4]  = '{12'h080, 1'b0,  2, 0, 0, 0, 5};
    tbl[5]  = '{12'h000, 1'b0,  3, 0, 0, 0, 5};
    tbl[6]  = '{12'h024, 1'b0,  5, 0, 0, 0, 5};  // '3'+'6' together
    tbl[7]  = '{12'h000, 1'b0,  1, 0, 0, 0, 5};
    tbl[8]  = '{12'h040, 1'b1,  4, 0, 0, 0, 5};  // '7' while enabled
    tbl[9]  = '{12'h000, 1'b1,  3, 0, 0, 0, 5};
    tbl[10] = '{12'h200, 1'b1,  4, 0, 1, 0, 5};  // '*'
    tbl[11] = '{12'h000, 1'b1,  3, 0, 0, 0, 5};
    tbl[12] = '{12'h800, 1'b1,  4, 0, 0, 1, 5};  // '#'
    tbl[13] = '{12'h000, 1'b0,  3, 0, 0, 0, 5};
    tbl[14] = '{12'h400, 1'b0,  4, 1, 0, 0, 0};  // '0'
    tbl[15] = '{12'h000, 1'b0,  3, 0, 0, 0, 0};
    tbl[16] = '{12'h400, 1'b0,  4, 1, 0, 0, 0};  // '0' again after full release
    tbl[17] = '{12'h000, 1'b0,  2, 0, 0, 0, 0};
    tbl[18] = '{12'h400, 1'b0,  4, 0, 0, 0, 0};  // re-press too soon
    tbl[19] = '{12'h000, 1'b0,  3, 0, 0, 0, 0};

    model_reset();
    repeat (3) @(negedge clock);
    check_reset_values();
    clearn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      seg_load = 0; seg_start = 0; seg_clear = 0;
      for (int s = 0; s < tbl[i].scans; s++) run_scan(tbl[i].keys, tbl[i].en);
      check_segment(i, tbl[i].n_load, tbl[i].n_start, tbl[i].n_clear, tbl[i].digit_end);
    end

    // Reset while '9' is mid-debounce, then keep holding it.
    run_scan(12'h100, 1'b0);
    run_scan(12'h100, 1'b0);
    repeat (5) begin
      @(posedge clock);
      @(negedge clock);
    end
    clearn = 1'b0;
    #1;
    check_reset_values();
    @(negedge clock);
    @(negedge clock);
    check_reset_values();
    clearn = 1'b1;
    model_reset();
    seg_load = 0; seg_start = 0; seg_clear = 0;
    for (int s = 0; s < 4; s++) run_scan(12'h100, 1'b0);
    check_segment(20, 1, 0, 0, 9);

    // Randomised key activity against the reference model.
    rk  = '0;
    ren = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        sel = $urandom_range(0, 9);
        if (sel < 4)       rk = '0;
        else if (sel == 9) rk = (12'h001 << $urandom_range(0, 11)) | (12'h001 << $urandom_range(0, 11));
        else               rk = 12'h001 << $urandom_range(0, 11);
        ren = ($urandom_range(0, 3) == 0);
      end
      run_scan(rk, ren);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
